// File: rtl/servo_cmd_controller.sv
// servo_cmd_controller
//   Parses 3-character servo commands ('P', digit '0'..'7', '#') from the
//   UART receiver. It loads the servo position and waits for the servo to
//   settle. It then answers through the UART transmitter with 'K' (command
//   applied) or 'E' (bad character, parity error or inter-character timeout).
//
// Ports
//   clock       system clock, rising edge
//   reset       asynchronous, active-low
//   fim_rx      1-cycle pulse: rx_dado / parity_ok valid
//   rx_dado     received character (N_BITS)
//   parity_ok   received character passed parity
//   pronto_tx   1-cycle pulse: transmitter finished
//   partida_tx  1-cycle transmitter start pulse (registered)
//   tx_dado     character to transmit, held until pronto_tx
//   posicao     servo position select (3 bits)
//   ocupado     block busy; received characters are dropped while set
//   erro        sticky error flag (set by 'E', cleared by 'K')
//   db_estado   registered state code for the debug display
//
// Handshake: fim_rx and pronto_tx are single-cycle strobes sampled on the
// rising edge. partida_tx is a single-cycle strobe. tx_dado is already valid
// in the partida_tx cycle and stays stable until the edge that samples
// pronto_tx.
module servo_cmd_controller #(
  parameter int N_BITS         = 7,
  parameter int SETTLE_CYCLES  = 1_000_000,
  parameter int TIMEOUT_CYCLES = 5_000_000,
  parameter int POS_INICIAL    = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fim_rx,
  input  logic [N_BITS-1:0] rx_dado,
  input  logic              parity_ok,
  input  logic              pronto_tx,
  output logic              partida_tx,
  output logic [N_BITS-1:0] tx_dado,
  output logic [2:0]        posicao,
  output logic              ocupado,
  output logic              erro,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL    = 4'd0,
    S_ESPERA_CMD = 4'd1,
    S_ESPERA_DIG = 4'd2,
    S_ESPERA_FIM = 4'd3,
    S_ATUALIZA   = 4'd4,
    S_ACOMODA    = 4'd5,
    S_TX_OK      = 4'd6,
    S_TX_ERRO    = 4'd7,
    S_ESPERA_TX  = 4'd8
  } state_t;

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [N_BITS-1:0] CHAR_K = N_BITS'(7'h4B);
  localparam logic [N_BITS-1:0] CHAR_E = N_BITS'(7'h45);

  state_t          state_q, state_d;
  logic [SW-1:0]   settle_q;
  logic [TW-1:0]   to_cnt_q;
  logic [2:0]      pend_q;

  // With an 8-bit UART the character compares only hold if bit 7 is clear.
  logic hi_zero;
  if (N_BITS > 7) begin : g_hi
    assign hi_zero = ~|rx_dado[N_BITS-1:7];
  end else begin : g_no_hi
    assign hi_zero = 1'b1;
  end

  logic is_p, is_hash, is_digit, to_expired, settle_done, in_cmd_wait;
  assign is_p        = hi_zero && (rx_dado[6:0] == 7'h50);
  assign is_hash     = hi_zero && (rx_dado[6:0] == 7'h23);
  assign is_digit    = hi_zero && (rx_dado[6:3] == 4'b0110);  // 0x30..0x37
  assign to_expired  = (to_cnt_q == TIMEOUT_LAST);
  assign settle_done = (settle_q == SETTLE_LAST);
  assign in_cmd_wait = (state_q == S_ESPERA_DIG) || (state_q == S_ESPERA_FIM);

  // Next state. In the waiting states fim_rx is tested before the timeout,
  // so a character arriving on the expiry cycle still counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INICIAL:    state_d = S_ESPERA_CMD;
      S_ESPERA_CMD: begin
        if (fim_rx) begin
          if (!parity_ok)  state_d = S_TX_ERRO;
          else if (is_p)   state_d = S_ESPERA_DIG;
        end
      end
      S_ESPERA_DIG: begin
        if (fim_rx)          state_d = (parity_ok && is_digit) ? S_ESPERA_FIM : S_TX_ERRO;
        else if (to_expired) state_d = S_TX_ERRO;
      end
      S_ESPERA_FIM: begin
        if (fim_rx)          state_d = (parity_ok && is_hash) ? S_ATUALIZA : S_TX_ERRO;
        else if (to_expired) state_d = S_TX_ERRO;
      end
      S_ATUALIZA:   state_d = S_ACOMODA;
      S_ACOMODA:    if (settle_done) state_d = S_TX_OK;
      S_TX_OK:      state_d = S_ESPERA_TX;
      S_TX_ERRO:    state_d = S_ESPERA_TX;
      S_ESPERA_TX:  if (pronto_tx) state_d = S_ESPERA_CMD;
      default:      state_d = S_INICIAL;
    endcase
  end

  // All outputs are registered from the next state, so they line up with
  // the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_INICIAL;
      db_estado  <= 4'd0;
      partida_tx <= 1'b0;
      tx_dado    <= '0;
      posicao    <= 3'(POS_INICIAL);
      ocupado    <= 1'b0;
      erro       <= 1'b0;
      pend_q     <= 3'd0;
      settle_q   <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      db_estado  <= state_d;
      partida_tx <= (state_d == S_TX_OK) || (state_d == S_TX_ERRO);
      ocupado    <= (state_d == S_ATUALIZA) || (state_d == S_ACOMODA) ||
                    (state_d == S_TX_OK) || (state_d == S_TX_ERRO) ||
                    (state_d == S_ESPERA_TX);

      // Counts only while sitting in a waiting state with no character.
      // Any character, state change or other state clears it.
      if (in_cmd_wait && (state_d == state_q) && !fim_rx)
        to_cnt_q <= to_cnt_q + TW'(1);
      else
        to_cnt_q <= '0;

      if ((state_q == S_ACOMODA) && !settle_done)
        settle_q <= settle_q + SW'(1);
      else
        settle_q <= '0;

      if ((state_q == S_ESPERA_DIG) && (state_d == S_ESPERA_FIM))
        pend_q <= rx_dado[2:0];

      if (state_q == S_ATUALIZA)
        posicao <= pend_q;

      if (state_d == S_TX_OK) begin
        tx_dado <= CHAR_K;
        erro    <= 1'b0;
      end else if (state_d == S_TX_ERRO) begin
        tx_dado <= CHAR_E;
        erro    <= 1'b1;
      end else if ((state_q == S_ESPERA_TX) && pronto_tx) begin
        tx_dado <= '0;
      end
    end
  end

endmodule

// File: tb/tb_servo_cmd_controller.sv
module tb_servo_cmd_controller;

  localparam int N_BITS = 7;

  logic              clk;
  logic              rst_n;
  logic              fim_rx;
  logic [N_BITS-1:0] rx_dado;
  logic              parity_ok;
  logic              pronto_tx;
  logic              partida_tx;
  logic [N_BITS-1:0] tx_dado;
  logic [2:0]        posicao;
  logic              ocupado;
  logic              erro;
  logic [3:0]        db_estado;

  servo_cmd_controller #(
    .N_BITS(N_BITS), .SETTLE_CYCLES(10), .TIMEOUT_CYCLES(50), .POS_INICIAL(0)
  ) dut (
    .clock(clk), .reset(rst_n), .fim_rx(fim_rx), .rx_dado(rx_dado),
    .parity_ok(parity_ok), .pronto_tx(pronto_tx), .partida_tx(partida_tx),
    .tx_dado(tx_dado), .posicao(posicao), .ocupado(ocupado), .erro(erro),
    .db_estado(db_estado)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [N_BITS-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transmitter model ----------------
  initial begin
    pronto_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (partida_tx) begin
        repeat (20) @(negedge clk);
        pronto_tx = 1'b1;
        @(negedge clk);
        pronto_tx = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic prev_partida = 1'b0;
  always @(negedge clk) begin
    if (partida_tx) begin
      n_checks++;
      if (prev_partida) begin
        n_errors++;
        $display("FAIL partida_width: got 2 consecutive cycles expected 1");
      end else if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_tx: got tx_dado %0h expected no transmission", tx_dado);
      end else begin
        logic [N_BITS-1:0] e;
        e = exp_q.pop_front();
        if (tx_dado !== e) begin
          n_errors++;
          $display("FAIL tx_char: got %0h expected %0h", tx_dado, e);
        end
      end
    end
    prev_partida <= partida_tx;
  end

  // ---------------- driver tasks ----------------
  task automatic send_char(input logic [6:0] ch, input logic par);
    @(negedge clk);
    rx_dado   = N_BITS'(ch);
    parity_ok = par;
    fim_rx    = 1'b1;
    @(negedge clk);
    fim_rx    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k;
    k = 0;
    while (!(db_estado == 4'd1 && !ocupado) && k < max) begin
      @(negedge clk);
      k++;
    end
    if (k >= max) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_idle_timeout: got state %0d expected 1 within %0d cycles", name, db_estado, max);
    end
  endtask

  // Negedges (after the current point) until partida_tx is seen.
  task automatic count_to_partida(input int max, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!partida_tx && k < max);
  endtask

  // ---------------- command vectors ----------------
  typedef struct packed {
    logic [2:0]  n;
    logic [27:0] chars;   // char i at chars[7*i +: 7]
    logic [3:0]  par;     // parity_ok for char i at par[i]
    logic [6:0]  exp_tx;
    logic [2:0]  exp_pos;
    logic        exp_erro;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [6:0] c0, input logic [6:0] c1,
                              input logic [6:0] c2, input logic [6:0] c3, input logic [3:0] par,
                              input logic [6:0] tx, input logic [2:0] pos, input logic er);
    vec_t v;
    v.n = 3'(n);
    v.chars = {c3, c2, c1, c0};
    v.par = par;
    v.exp_tx = tx;
    v.exp_pos = pos;
    v.exp_erro = er;
    return v;
  endfunction

  task automatic apply_rec(input vec_t v, input string name);
    exp_q.push_back(N_BITS'(v.exp_tx));
    for (int i = 0; i < int'(v.n); i++)
      send_char(v.chars[7*i +: 7], v.par[i]);
    wait_idle(name, 200);
    check({name, "_pos"}, 32'(posicao), 32'(v.exp_pos));
    check({name, "_erro"}, 32'(erro), 32'(v.exp_erro));
    check({name, "_txclr"}, 32'(tx_dado), 32'd0);
    check({name, "_sb_empty"}, exp_q.size(), 32'd0);
  endtask

  localparam logic [6:0] K = 7'h4B, E = 7'h45, P = 7'h50, H = 7'h23, X = 7'h58;

  vec_t tbl[12];
  int k;
  int cnt;

  initial begin
    // Table: starting from posicao=5 after the hand-written 'P5#'.
    tbl[0]  = mk(3, P, 7'h39, H, 0, 4'b0111, E, 3'd5, 1'b1); // '9' not a digit
    tbl[1]  = mk(3, P, 7'h32, H, 0, 4'b0111, K, 3'd2, 1'b0);
    tbl[2]  = mk(4, X, P, 7'h33, H, 4'b1011, E, 3'd2, 1'b1); // X ignored, bad parity on '3'
    tbl[3]  = mk(3, P, 7'h37, H, 0, 4'b0111, K, 3'd7, 1'b0); // top digit
    tbl[4]  = mk(3, P, 7'h34, X, 0, 4'b0111, E, 3'd7, 1'b1); // wrong terminator
    tbl[5]  = mk(1, P, 0, 0, 0, 4'b0000, E, 3'd7, 1'b1);     // parity error in ESPERA_CMD
    tbl[6]  = mk(3, P, 7'h30, H, 0, 4'b0111, K, 3'd0, 1'b0); // bottom digit
    tbl[7]  = mk(3, P, 7'h34, H, 0, 4'b0011, E, 3'd0, 1'b1); // bad parity on '#'
    tbl[8]  = mk(3, P, 7'h2F, H, 0, 4'b0111, E, 3'd0, 1'b1); // just below '0'
    tbl[9]  = mk(3, P, 7'h38, H, 0, 4'b0111, E, 3'd0, 1'b1); // just above '7'
    tbl[10] = mk(3, P, P, H, 0, 4'b0111, E, 3'd0, 1'b1);     // 'P' as digit
    tbl[11] = mk(3, P, 7'h36, H, 0, 4'b0111, K, 3'd6, 1'b0);

    rst_n = 1'b0;
    fim_rx = 1'b0;
    rx_dado = '0;
    parity_ok = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_pos", 32'(posicao), 32'd0);
    check("rst_state", 32'(db_estado), 32'd0);
    check("rst_partida", 32'(partida_tx), 32'd0);
    check("rst_txdado", 32'(tx_dado), 32'd0);
    check("rst_ocupado", 32'(ocupado), 32'd0);
    check("rst_erro", 32'(erro), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_state_1", 32'(db_estado), 32'd1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (partida_tx) cnt++;
    end
    check("idle_no_partida", cnt, 32'd0);
    check("idle_state_hold", 32'(db_estado), 32'd1);

    // ---- 'P','5','#' with exact timing ----
    exp_q.push_back(N_BITS'(K));
    send_char(P, 1'b1);
    send_char(7'h35, 1'b1);
    send_char(H, 1'b1);
    check("p5_pos_before", 32'(posicao), 32'd0);   // '#' cycle + 1
    @(negedge clk);
    check("p5_pos_after", 32'(posicao), 32'd5);    // '#' cycle + 2
    count_to_partida(40, k);
    check("p5_partida_delay", 32'(k + 1), 32'd11);  // pulse in cycle 12 after '#'
    check("p5_txdado", 32'(tx_dado), 32'(K));
    check("p5_erro", 32'(erro), 32'd0);
    wait_idle("p5", 100);
    check("p5_state_back", 32'(db_estado), 32'd1);
    check("p5_txclr", 32'(tx_dado), 32'd0);

    // ---- table-driven commands ----
    for (int i = 0; i < 12; i++)
      apply_rec(tbl[i], $sformatf("rec%0d", i));

    // ---- timeout in ESPERA_DIG ----
    exp_q.push_back(N_BITS'(E));
    send_char(P, 1'b1);
    count_to_partida(100, k);
    check("to_dig_delay", k, 32'd50);
    check("to_dig_erro", 32'(erro), 32'd1);
    wait_idle("to_dig", 100);
    check("to_dig_pos", 32'(posicao), 32'd6);

    // ---- timeout in ESPERA_FIM, counter restarted by the digit ----
    exp_q.push_back(N_BITS'(E));
    send_char(P, 1'b1);
    repeat (30) @(negedge clk);
    send_char(7'h33, 1'b1);
    check("to_fim_state", 32'(db_estado), 32'd3);
    count_to_partida(100, k);
    check("to_fim_delay", k, 32'd50);
    wait_idle("to_fim", 100);
    check("to_fim_pos", 32'(posicao), 32'd6);

    apply_rec(mk(3, P, 7'h32, H, 0, 4'b0111, K, 3'd2, 1'b0), "after_to");

    // ---- reset during ACOMODA ----
    send_char(P, 1'b1);
    send_char(7'h37, 1'b1);
    send_char(H, 1'b1);
    repeat (4) @(negedge clk);
    check("rstmid_state", 32'(db_estado), 32'd5);
    check("rstmid_pos_upd", 32'(posicao), 32'd7);
    rst_n = 1'b0;
    #1;
    check("rstmid_pos_async", 32'(posicao), 32'd0);
    check("rstmid_state_async", 32'(db_estado), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (partida_tx) cnt++;
    end
    check("rstmid_no_partida", cnt, 32'd0);
    check("rstmid_resume", 32'(db_estado), 32'd1);
    check("rstmid_pos_hold", 32'(posicao), 32'd0);
    apply_rec(mk(3, P, 7'h31, H, 0, 4'b0111, K, 3'd1, 1'b0), "after_rst");

    // ---- final report ----
    repeat (5) @(negedge clk);
    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/servo_cmd_controller.md
Name: servo_cmd_controller

Overview:
Control unit that sequences the serial/servo datapath. It parses 3-character commands from the UART receiver ('P', digit '0'-'7', '#'), loads the servo position register, and waits a settle time. It then drives the UART transmitter handshake to return an acknowledge ('K') or error ('E') character. It sits between the RX/TX/PWM datapath and the top level, replacing the manual transmit button path.

Parameters:
N_BITS, 7, UART data width (7 or 8); character compares use the low 7 bits, and bit 7 must be 0 when N_BITS=8.
SETTLE_CYCLES, 1_000_000, clock cycles held in ACOMODA after a position update (20 ms at 50 MHz).
TIMEOUT_CYCLES, 5_000_000, maximum gap between characters of one command (100 ms at 50 MHz).
POS_INICIAL, 0, position loaded at reset (3 bits).

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
fim_rx  input  1  one-cycle pulse: rx_dado and parity_ok are valid this cycle.
rx_dado  input  N_BITS  received character.
parity_ok  input  1  1 = received character passed the parity check.
pronto_tx  input  1  one-cycle pulse: transmitter finished the current character.
partida_tx  output  1  one-cycle start pulse to the transmitter.
tx_dado  output  N_BITS  character to transmit; stable from partida_tx until pronto_tx.
posicao  output  3  servo position select to the PWM generator.
ocupado  output  1  1 in ATUALIZA, ACOMODA, TX_OK, TX_ERRO and ESPERA_TX.
erro  output  1  sticky error flag.
db_estado  output  4  current state code, for the hexa7seg display.

Behaviour:
- Reset (reset=0): state INICIAL; partida_tx=0, tx_dado=0, posicao=POS_INICIAL, ocupado=0, erro=0, db_estado=0; both counters cleared.
- State codes: INICIAL=0, ESPERA_CMD=1, ESPERA_DIG=2, ESPERA_FIM=3, ATUALIZA=4, ACOMODA=5, TX_OK=6, TX_ERRO=7, ESPERA_TX=8. Codes 9-15 are unused and go to INICIAL on the next cycle.
- INICIAL -> ESPERA_CMD unconditionally after 1 cycle.
- ESPERA_CMD, on fim_rx:
  - parity_ok=1 and char='P' (0x50) -> ESPERA_DIG.
  - parity_ok=1 and any other char is ignored; stay, no error.
  - parity_ok=0 -> TX_ERRO.
- ESPERA_DIG, on fim_rx:
  - char in 0x30-0x37 with parity_ok=1 -> latch char[2:0] into a pending register, then ESPERA_FIM.
  - anything else -> TX_ERRO.
- ESPERA_FIM, on fim_rx:
  - char='#' (0x23) with parity_ok=1 -> ATUALIZA.
  - anything else -> TX_ERRO.
- Timeout counter: runs only in ESPERA_DIG and ESPERA_FIM, and clears on every fim_rx and on entering those states. Reaching TIMEOUT_CYCLES-1 -> TX_ERRO.
- If fim_rx and timeout expiry occur in the same cycle, fim_rx wins.
- ATUALIZA (1 cycle): posicao <= pending, clear the settle counter, -> ACOMODA. posicao changes on the edge leaving ATUALIZA, 2 cycles after the '#' fim_rx cycle.
- ACOMODA: count SETTLE_CYCLES cycles, then -> TX_OK.
- TX_OK (1 cycle): partida_tx=1, tx_dado='K' (0x4B), erro <= 0, -> ESPERA_TX.
- TX_ERRO (1 cycle): partida_tx=1, tx_dado='E' (0x45), erro <= 1, posicao unchanged, -> ESPERA_TX.
- ESPERA_TX: hold tx_dado; on pronto_tx -> ESPERA_CMD and tx_dado <= 0.
- Any fim_rx while ocupado=1 is dropped: no state change, no error.
- partida_tx is registered and never high for more than 1 consecutive cycle.
- Reset asserted mid-command or mid-transmission: the pending position is discarded; posicao returns to POS_INICIAL.
- db_estado is the registered state code, zero-extended to 4 bits.

Test Plan:
- Bench settings for all scenarios: SETTLE_CYCLES=10, TIMEOUT_CYCLES=50; the bench returns pronto_tx 20 cycles after each partida_tx.
- Reset then idle: posicao=0, db_estado=1 one cycle after reset release, partida_tx=0 for 100 cycles.
- Send 'P','5','#' with parity ok: posicao=5 two cycles after '#'; partida_tx pulses 12 cycles after '#' with tx_dado=0x4B; erro=0; state returns to 1 after pronto_tx.
- Send 'P','9','#': after '9', a single partida_tx with tx_dado=0x45; erro=1; posicao keeps its old value; the following '#' is dropped because the block is busy.
- Send 'P' then nothing for 60 cycles: TX_ERRO reached at 50 cycles, 'E' sent, erro=1. Next send 'P','2','#': posicao=2, 'K' sent, erro=0.
- Send 'X' then 'P','3','#' with parity_ok=0 on '3': 'X' is ignored (no tx); the bad '3' produces 'E' and posicao is unchanged.
- Assert reset during ACOMODA after 'P','7','#': posicao=0 immediately, partida_tx never pulses, and the block resumes in ESPERA_CMD.
